keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
Scan sequencer and debounce controller for the 4x4 matrix keypad. It drives one-hot row selects, samples the column lines, and debounces both press and release. Each accepted key produces exactly one event, which shifts into a two-digit register read by the dual seven-segment display multiplexer. It sits between the keypad pins and the seven-segment decoder, replacing free-running scan/debounce logic with one explicit FSM.

Parameters:
SCAN_DIV, 4096, clock cycles each row is driven before sampling/advancing (min 4)
DB_CYCLES, 480000, consecutive stable cycles needed to accept a press or a release (min 2)
REPEAT_CYCLES, 24000000, hold time between auto-repeat events (used only with KEYPAD_REPEAT_EN)

Ports:
int_osc  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
col  input  4  raw keypad columns, active-low (pull-ups), asynchronous
r_sel  output  4  row drive, active-low one-hot
key_valid  output  1  one-cycle pulse per accepted key
key_code  output  4  hex code of last accepted key; held until next accept
dig_new  output  4  most recent digit (right display)
dig_old  output  4  previous digit (left display)
busy  output  1  high whenever FSM is not in SCAN

Behaviour:
- Clock int_osc; reset is synchronous, active-high. All flops clear on the reset cycle.
- Reset values: r_sel=4'b1110 (row 0), key_valid=0, key_code=0, dig_new=0, dig_old=0, busy=0, FSM=SCAN, counters=0.
- col passes through a 2-flop synchronizer. All decisions below use the synchronized col (csync), which has 2 cycles latency.
- Keymap, [row][col]: row0 1,2,3,A; row1 4,5,6,B; row2 7,8,9,C; row3 E,0,F,D.
- SCAN:
  - Dwell counter runs 0..SCAN_DIV-1. csync is sampled only on count SCAN_DIV-1, which allows settling.
  - If no bit of csync is low at the sample: row advances 0→1→2→3→0 (wrap) and the counter clears.
  - If any bit is low: latch row and the lowest-index low column, go to DEBOUNCE, clear counter, keep r_sel frozen.
- DEBOUNCE:
  - Count while the latched column stays low.
  - If it goes high on any cycle: return to SCAN at the next row with no event.
  - When the count reaches DB_CYCLES-1 with the column still low: for exactly one cycle, key_valid=1, key_code=map, dig_old<=dig_new, dig_new<=map (all registered in the same cycle). Then go to HELD.
- HELD:
  - r_sel frozen; all other keys ignored.
  - When the latched column goes high: go to REL_DB with counter cleared.
- REL_DB:
  - Counts consecutive high cycles; any low sample returns to HELD (no new event).
  - At DB_CYCLES-1: go to SCAN at the next row.
- Simultaneous keys: only the first detected key is tracked; others are ignored until its release completes.
- Reset mid-operation aborts any state. No key_valid is emitted on or after the reset cycle.
- busy = (state != SCAN), registered.
- No backpressure: consumers must capture key_valid in the same cycle.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: in HELD, a repeat counter runs. Every REPEAT_CYCLES continuous held cycles it re-emits key_valid with the same code and shifts the digits again. The counter clears on leaving HELD.
- Undefined: no repeat logic is generated, REPEAT_CYCLES is ignored, and exactly one event occurs per press.

Decomposition:
- Package keypad_pkg holds:
  - state enum {SCAN, DEBOUNCE, HELD, REL_DB}
  - 4x4 keymap constant array
  - row one-hot constant ROW_SEL[4]
  - counter-width localparam helper ($clog2)
- Sub-module keypad_col_sync: 4-bit, 2-flop synchronizer with synchronous reset to 4'b1111.

Test Plan (SCAN_DIV=4, DB_CYCLES=8, REPEAT_CYCLES=32):
1. Assert reset 2 cycles → r_sel=1110, dig_new=dig_old=0, key_valid=0, busy=0; r_sel steps 1101, 1011, 0111, 1110 every 4 cycles.
2. Hold col=1011 while r_sel=1101 ('6') for 40 cycles → exactly one key_valid pulse, key_code=6, dig_new=6, dig_old=0, r_sel frozen at 1101 until release plus 8 high cycles.
3. Bounce: col=1110 low 3 cycles on row 0, then high → no pulse, busy drops, scan resumes at r_sel=1101.
4. Press '1' then 'A' (row0 col0, row0 col3), each with a clean release → dig_old=1, dig_new=A, two pulses total.
5. While holding '9', glitch col high for 3 cycles, then low again; also press a second column → no extra pulse; release accepted only after 8 continuous high cycles.
6. Assert reset during DEBOUNCE (count 5) → no pulse, all outputs at reset values next cycle. With KEYPAD_REPEAT_EN: holding '0' for 100 cycles → 1 initial pulse plus 2 repeat pulses.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants for the keypad scan/debounce controller: state codes, keymap,
// row drive patterns and counter sizing helpers.
package keypad_pkg;

    typedef logic [1:0] state_t;

    localparam state_t SCAN     = 2'd0;
    localparam state_t DEBOUNCE = 2'd1;
    localparam state_t HELD     = 2'd2;
    localparam state_t REL_DB   = 2'd3;

    // Indexed [row][col]; row 3 carries the E/0/F/D keys.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    localparam logic [3:0] ROW_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Bits needed for a counter that runs 0..n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [1:0] lowest_low(input logic [3:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!c[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad column lines.
module keypad_col_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // Idle columns read high, so reset to "no key".
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner with press/release debounce feeding a two-digit shift register.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV      = 4096,
    parameter int unsigned DB_CYCLES     = 480000,
    parameter int unsigned REPEAT_CYCLES = 24000000
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] r_sel,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] dig_new,
    output logic [3:0] dig_old,
    output logic       busy
);

    if (SCAN_DIV < 4 || DB_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("keypad_scan_ctrl: parameter out of range");
    end

    localparam int unsigned CNT_MAX = (SCAN_DIV > DB_CYCLES) ? SCAN_DIV : DB_CYCLES;
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);

    logic [3:0]       csync;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       row_q, row_d;
    logic [1:0]       lcol_q, lcol_d;
    logic             key_valid_q;
    logic [3:0]       key_code_q;
    logic [3:0]       dig_new_q;
    logic [3:0]       dig_old_q;
    logic             busy_q;
    logic             emit;
    logic             col_up;
    logic [3:0]       code;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RPT_W = cnt_width(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

    keypad_col_sync u_col_sync (
        .clk   (int_osc),
        .reset (reset),
        .d     (col),
        .q     (csync)
    );

    // High means the tracked key's column has been let go.
    assign col_up = csync[lcol_q];
    assign code   = KEYMAP[row_q][lcol_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        lcol_d  = lcol_q;
        emit    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_d   = '0;
`endif
        case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (&csync) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        lcol_d  = lowest_low(csync);
                        state_d = DEBOUNCE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (col_up) begin
                    state_d = SCAN;
                    row_d   = row_q + 2'd1;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    emit    = 1'b1;
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (col_up) begin
                    state_d = REL_DB;
                    cnt_d   = '0;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (rpt_q == RPT_LAST) begin
                    emit = 1'b1;
                end else begin
                    rpt_d = rpt_q + RPT_W'(1);
                end
`endif
            end
            REL_DB: begin
                if (!col_up) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = SCAN;
                    row_d   = row_q + 2'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge int_osc) begin
        if (reset) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            row_q       <= 2'd0;
            lcol_q      <= 2'd0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            dig_new_q   <= 4'h0;
            dig_old_q   <= 4'h0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            lcol_q      <= lcol_d;
            key_valid_q <= emit;
            busy_q      <= (state_d != SCAN);
            if (emit) begin
                key_code_q <= code;
                dig_new_q  <= code;
                dig_old_q  <= dig_new_q;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge int_osc) begin
        if (reset) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`endif

    assign r_sel     = ROW_SEL[row_q];
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign dig_new   = dig_new_q;
    assign dig_old   = dig_old_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized and directed bench for keypad_scan_ctrl against a behavioural keypad model.
module tb_keypad_scan_ctrl;

    localparam int unsigned SCAN_DIV      = 4;
    localparam int unsigned DB_CYCLES     = 8;
    localparam int unsigned REPEAT_CYCLES = 32;

    logic        int_osc = 1'b0;
    logic        reset   = 1'b1;
    logic [3:0]  col;
    logic [3:0]  r_sel;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [3:0]  dig_new;
    logic [3:0]  dig_old;
    logic        busy;
    logic [15:0] pressed = '0;
    logic        chk_en  = 1'b0;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_pulse = 0;

    keypad_scan_ctrl #(
        .SCAN_DIV      (SCAN_DIV),
        .DB_CYCLES     (DB_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) dut (
        .int_osc   (int_osc),
        .reset     (reset),
        .col       (col),
        .r_sel     (r_sel),
        .key_valid (key_valid),
        .key_code  (key_code),
        .dig_new   (dig_new),
        .dig_old   (dig_old),
        .busy      (busy)
    );

    always #5 int_osc = ~int_osc;

    // Physical matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && (r_sel[r] == 1'b0)) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    function automatic logic [3:0] key_hex(input int r, input int c);
        string map;
        byte   ch;
        map = "123A456B789CE0FD";
        ch  = map[r*4+c];
        if (ch >= 8'd65) return 4'(ch - 8'd55);
        return 4'(ch - 8'd48);
    endfunction

    // Reference model: mode 0 scanning, 1 confirming a press, 2 key down, 3 confirming release.
    int         m_mode  = 0;
    int         m_dwell = 0;
    int         m_run   = 0;
    int         m_rpt   = 0;
    int         m_row   = 0;
    int         m_col   = 0;
    logic [3:0] m_hist0 = 4'hF;
    logic [3:0] m_hist1 = 4'hF;
    logic       m_valid = 1'b0;
    logic [3:0] m_code  = 4'h0;
    logic [3:0] m_new   = 4'h0;
    logic [3:0] m_old   = 4'h0;

    task automatic accept();
        m_valid = 1'b1;
        m_code  = key_hex(m_row, m_col);
        m_old   = m_new;
        m_new   = m_code;
    endtask

    task automatic model_step(input logic rst, input logic [3:0] c);
        logic [3:0] cs;
        cs      = m_hist1;
        m_hist1 = m_hist0;
        m_hist0 = c;
        m_valid = 1'b0;
        if (rst) begin
            m_mode = 0; m_dwell = 0; m_run = 0; m_rpt = 0; m_row = 0; m_col = 0;
            m_hist0 = 4'hF; m_hist1 = 4'hF;
            m_code = 4'h0; m_new = 4'h0; m_old = 4'h0;
            return;
        end
        case (m_mode)
            0: begin
                if (m_dwell < int'(SCAN_DIV) - 1) begin
                    m_dwell++;
                end else begin
                    m_dwell = 0;
                    if (cs == 4'hF) begin
                        m_row = (m_row + 1) % 4;
                    end else begin
                        for (int i = 3; i >= 0; i--) if (!cs[i]) m_col = i;
                        m_run  = 0;
                        m_mode = 1;
                    end
                end
            end
            1: begin
                if (cs[m_col]) begin
                    m_mode = 0; m_row = (m_row + 1) % 4;
                end else if (m_run == int'(DB_CYCLES) - 1) begin
                    accept();
                    m_mode = 2; m_rpt = 0;
                end else begin
                    m_run++;
                end
            end
            2: begin
                if (cs[m_col]) begin
                    m_mode = 3; m_run = 0; m_rpt = 0;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (m_rpt == int'(REPEAT_CYCLES) - 1) begin
                        accept();
                        m_rpt = 0;
                    end else begin
                        m_rpt++;
                    end
`endif
                end
            end
            default: begin
                if (!cs[m_col]) begin
                    m_mode = 2; m_rpt = 0;
                end else if (m_run == int'(DB_CYCLES) - 1) begin
                    m_mode = 0; m_row = (m_row + 1) % 4;
                end else begin
                    m_run++;
                end
            end
        endcase
    endtask

    initial begin : model_proc
        forever begin
            @(posedge int_osc);
            model_step(reset, col);
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    initial begin : compare_proc
        forever begin
            @(negedge int_osc);
            if (chk_en) begin
                check("r_sel", r_sel, ~(4'b0001 << m_row));
                check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
                check("key_code", key_code, m_code);
                check("dig_new", dig_new, m_new);
                check("dig_old", dig_old, m_old);
                check("busy", {3'b0, busy}, {3'b0, (m_mode != 0)});
                if (key_valid) n_pulse++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge int_osc);
    endtask

    task automatic wait_busy(input int lim);
        int k;
        k = 0;
        @(negedge int_osc);
        while (!busy && k < lim) begin
            @(negedge int_osc);
            k++;
        end
        if (!busy) timeout_fail("wait_busy");
    endtask

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        @(negedge int_osc);
        while (busy && k < lim) begin
            @(negedge int_osc);
            k++;
        end
        if (busy) timeout_fail("wait_idle");
    endtask

    task automatic wait_pulse(input int lim);
        int k;
        k = 0;
        @(negedge int_osc);
        while (!key_valid && k < lim) begin
            @(negedge int_osc);
            k++;
        end
        if (!key_valid) timeout_fail("wait_pulse");
    endtask

    task automatic tap(input int r, input int c, input int hold);
        pressed[r*4+c] = 1'b1;
        wait_pulse(300);
        cyc(hold);
        pressed[r*4+c] = 1'b0;
        wait_idle(300);
    endtask

    // Pulse count sampled away from the negedge where the compare process updates it.
    task automatic check_pulses(input string name, input int base, input int exp);
        @(posedge int_osc);
        #1;
        n_cmp++;
        if (n_pulse - base != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d pulses, expected %0d", name, n_pulse - base, exp);
        end
    endtask

    initial begin : stim
        int p0;
        reset = 1'b1;
        cyc(2);
        chk_en = 1'b1;
        check("rst_r_sel", r_sel, 4'b1110);
        check("rst_dig_new", dig_new, 4'h0);
        check("rst_dig_old", dig_old, 4'h0);
        check("rst_busy", {3'b0, busy}, 4'h0);
        reset = 1'b0;
        cyc(4);
        check("scan_row1", r_sel, 4'b1101);
        cyc(4);
        check("scan_row2", r_sel, 4'b1011);
        cyc(4);
        check("scan_row3", r_sel, 4'b0111);
        cyc(4);
        check("scan_wrap", r_sel, 4'b1110);

        // Key '6'
        p0 = n_pulse;
        pressed[1*4+2] = 1'b1;
        wait_pulse(300);
        check("k6_code", key_code, 4'h6);
        check("k6_new", dig_new, 4'h6);
        check("k6_old", dig_old, 4'h0);
        cyc(10);
        check("k6_frozen", r_sel, 4'b1101);
        pressed[1*4+2] = 1'b0;
        wait_idle(300);
        check("k6_next_row", r_sel, 4'b1011);
        check_pulses("k6_pulses", p0, 1);

        // Short bounce on '1'
        p0 = n_pulse;
        pressed[0] = 1'b1;
        wait_busy(100);
        cyc(3);
        pressed[0] = 1'b0;
        wait_idle(50);
        check("bounce_row", r_sel, 4'b1101);
        check_pulses("bounce_pulses", p0, 0);

        // '1' then 'A'
        p0 = n_pulse;
        tap(0, 0, 3);
        tap(0, 3, 3);
        check("seq_old", dig_old, 4'h1);
        check("seq_new", dig_new, 4'hA);
        check_pulses("seq_pulses", p0, 2);

        // '9' with release glitch and a second column pressed
        p0 = n_pulse;
        pressed[2*4+2] = 1'b1;
        wait_pulse(300);
        cyc(4);
        pressed[2*4+2] = 1'b0;
        cyc(3);
        pressed[2*4+2] = 1'b1;
        pressed[2*4+0] = 1'b1;
        cyc(12);
        check("glitch_code", key_code, 4'h9);
        check("glitch_busy", {3'b0, busy}, 4'h1);
        pressed = '0;
        cyc(10);
        check("rel_not_yet", {3'b0, busy}, 4'h1);
        cyc(1);
        check("rel_done", {3'b0, busy}, 4'h0);
        check_pulses("glitch_pulses", p0, 1);

        // Reset during press debounce
        p0 = n_pulse;
        pressed[1*4+1] = 1'b1;
        wait_busy(100);
        cyc(5);
        reset = 1'b1;
        pressed = '0;
        cyc(1);
        check("mid_rst_r_sel", r_sel, 4'b1110);
        check("mid_rst_new", dig_new, 4'h0);
        check("mid_rst_old", dig_old, 4'h0);
        check("mid_rst_code", key_code, 4'h0);
        check("mid_rst_busy", {3'b0, busy}, 4'h0);
        reset = 1'b0;
        cyc(20);
        check_pulses("mid_rst_pulses", p0, 0);

`ifdef KEYPAD_REPEAT_EN
        p0 = n_pulse;
        pressed[3*4+1] = 1'b1;
        wait_pulse(300);
        cyc(70);
        pressed = '0;
        wait_idle(300);
        check_pulses("repeat_pulses", p0, 3);
`endif

        // Random presses, bounces, multi-key and occasional reset
        for (int it = 0; it < 60; it++) begin
            int r, c;
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            pressed[r*4+c] = 1'b1;
            if ($urandom_range(0, 4) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
            cyc($urandom_range(1, 60));
            if ($urandom_range(0, 3) == 0) begin
                pressed = '0;
                cyc($urandom_range(1, 6));
                pressed[r*4+c] = 1'b1;
                cyc($urandom_range(1, 20));
            end
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b1;
                cyc($urandom_range(1, 2));
                reset = 1'b0;
            end
            pressed = '0;
            cyc($urandom_range(0, 30));
        end
        cyc(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
